axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-port round-robin arbiter that shares one AXI read-master user port (trig/len/addr/ready/done/data/data_en) between two requesters, e.g. a test-pattern checker and a display/readback path.
- Latches the winning request, issues a single trigger pulse, and routes returned beats only to the owning requester.
- Counts the returned beats, and monitors each transaction with a watchdog.

Parameters:
ADDR_WIDTH, 26, width of request/master address
DATA_WIDTH, 32, width of read data
TIMEOUT_CYCLES, 4096, max cycles from trigger to master done before abort (>=16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 request; held with addr/len stable until req0_ack
req0_addr  in  ADDR_WIDTH  requester 0 start address
req0_len  in  8  requester 0 beat count (1..255; 0 illegal)
req0_ack  out  1  one-cycle pulse: request 0 accepted
req0_done  out  1  one-cycle pulse: request 0 transaction finished/aborted
req0_data  out  DATA_WIDTH  read data (broadcast copy of m_rd_data)
req0_data_en  out  1  beat valid for requester 0
req1_valid, req1_addr, req1_len, req1_ack, req1_done, req1_data, req1_data_en  as above for requester 1
m_rd_trig  out  1  trigger to read master
m_rd_addr  out  ADDR_WIDTH  latched address to master
m_rd_len  out  8  latched length to master
m_rd_ready  in  1  master idle
m_rd_done  in  1  master transaction-done pulse
m_rd_data  in  DATA_WIDTH  master read data
m_rd_data_en  in  1  master beat valid
busy  out  1  high from grant until return to IDLE
len_err  out  1  sticky: zero-length request seen
cnt_err  out  1  sticky: returned beats != requested len
timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (so requester 0 wins first), counters 0. Reset mid-transaction drops ownership immediately; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: when m_rd_ready=1 and any reqN_valid=1, pick the winner.
  - Single request: that requester.
  - Both: the requester != last_grant.
  - Latch addr/len into m_rd_addr/m_rd_len, set grant, pulse reqN_ack for that cycle, busy<=1.
  - If the latched len==0: set len_err, go to FIN with no trigger issued.
  - Otherwise go to ISSUE.
  - If m_rd_ready=0, no grant and no ack.
- ISSUE: m_rd_trig=1 for exactly one cycle (registered output, high only in ISSUE); clear beat and watchdog counters; then WAIT.
- WAIT:
  - Every m_rd_data_en increments the 8-bit beat counter.
  - When m_rd_done=1: go to FIN; if the beat count, including any beat with data_en in the same cycle, != len, set cnt_err.
  - Watchdog increments each cycle; on reaching TIMEOUT_CYCLES-1 without m_rd_done: set timeout, go to FIN.
- FIN:
  - Pulse reqN_done for the owner.
  - last_grant<=grant.
  - busy<=0.
  - Go to IDLE. A new grant is possible on the next cycle if m_rd_ready=1.
- Data routing (combinational):
  - reqN_data=m_rd_data for both requesters.
  - reqN_data_en = m_rd_data_en & grant==N & state in {WAIT,FIN}.
  - Beats outside a transaction are dropped.
  - Beats in FIN are routed but not counted.
- Latency: valid in IDLE -> ack same cycle -> m_rd_trig next cycle. Minimum request-to-request spacing is 4 cycles plus the master's transaction time.
- Requests arriving while busy are held off (no ack) and arbitrated at the next IDLE.
- Grant never changes while busy.
- Sticky error flags clear only on rst.

Test Plan:
- Single request: req0 addr=0x100, len=8, master returns 8 beats -> ack cycle 0, one m_rd_trig pulse with addr=0x100/len=8, req0_data_en 8 times, req1_data_en never, one req0_done, no errors.
- Contention: req0 and req1 both valid continuously, len=4 -> grants alternate 0,1,0,1 over 4 transactions, each with exactly 4 beats to the owner.
- Zero length: req1 len=0 -> req1_ack, len_err=1, no m_rd_trig, req1_done 2 cycles after ack.
- Short return: len=8, master gives 7 beats then done -> cnt_err=1, req0_done pulsed, arbiter back in IDLE.
- Watchdog: TIMEOUT_CYCLES=16, master never asserts done -> timeout=1 exactly 16 cycles after WAIT entry, done pulse, next request is served normally.
- Reset mid-WAIT: rst asserted after 3 of 8 beats -> all outputs 0 next cycle, no done pulse, last_grant=1, and a following req1-only request is granted.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read-master user port between two requesters,
// with beat routing to the owner, beat counting and a per-transaction watchdog.
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [7:0]            req0_len,
   output logic                  req0_ack,
   output logic                  req0_done,
   output logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_data_en,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [7:0]            req1_len,
   output logic                  req1_ack,
   output logic                  req1_done,
   output logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_data_en,
   output logic                  m_rd_trig,
   output logic [ADDR_WIDTH-1:0] m_rd_addr,
   output logic [7:0]            m_rd_len,
   input  logic                  m_rd_ready,
   input  logic                  m_rd_done,
   input  logic [DATA_WIDTH-1:0] m_rd_data,
   input  logic                  m_rd_data_en,
   output logic                  busy,
   output logic                  len_err,
   output logic                  cnt_err,
   output logic                  timeout
);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
   state_t state;
   logic grant, last_grant, start, win, rx;
   logic [7:0] beats, sel_len;
   logic [WW-1:0] wd;
   assign start = state == IDLE && m_rd_ready && (req0_valid || req1_valid);
   // on contention the requester that did not win last goes next
   assign win = req1_valid && (!req0_valid || !last_grant);
   assign sel_len = win ? req1_len : req0_len;
   assign req0_ack = start && !win;
   assign req1_ack = start && win;
   assign rx = state == WAIT || state == FIN;
   assign req0_data = m_rd_data;
   assign req1_data = m_rd_data;
   assign req0_data_en = m_rd_data_en && rx && !grant;
   assign req1_data_en = m_rd_data_en && rx && grant;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= 1'b0;
         last_grant <= 1'b1;
         beats <= '0;
         wd <= '0;
         m_rd_trig <= 1'b0;
         m_rd_addr <= '0;
         m_rd_len <= '0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         busy <= 1'b0;
         len_err <= 1'b0;
         cnt_err <= 1'b0;
         timeout <= 1'b0;
      end else begin
         m_rd_trig <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               grant <= win;
               m_rd_addr <= win ? req1_addr : req0_addr;
               m_rd_len <= sel_len;
               busy <= 1'b1;
               if (sel_len == 8'd0) begin
                  len_err <= 1'b1;
                  state <= FIN;
               end else begin
                  m_rd_trig <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               beats <= '0;
               wd <= '0;
               state <= WAIT;
            end
            WAIT: begin
               beats <= beats + 8'(m_rd_data_en);
               if (m_rd_done) begin
                  // the beat arriving alongside done still belongs to this transaction
                  if (9'(beats) + 9'(m_rd_data_en) != 9'(m_rd_len)) cnt_err <= 1'b1;
                  state <= FIN;
               end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                  timeout <= 1'b1;
                  state <= FIN;
               end else wd <= wd + 1'b1;
            end
            FIN: begin
               req0_done <= !grant;
               req1_done <= grant;
               last_grant <= grant;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scenarios against a transaction-timeline model of the arbiter,
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_axi_rd_arbiter;
   localparam int TO = 16;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req1_valid = 0;
   logic [25:0] req0_addr = 0, req1_addr = 0;
   logic [7:0] req0_len = 0, req1_len = 0;
   logic req0_ack, req0_done, req0_data_en, req1_ack, req1_done, req1_data_en;
   logic [31:0] req0_data, req1_data;
   logic m_rd_trig, busy, len_err, cnt_err, timeout;
   logic [25:0] m_rd_addr;
   logic [7:0] m_rd_len;
   logic m_rd_ready, m_rd_done, m_rd_data_en;
   logic [31:0] m_rd_data;
   int tests = 0, fails = 0;
   bit en = 0;
   int bfm_beats = 0;
   bit bfm_done = 1, bfm_same = 0;
   // model state: owner (-1 idle), cycles since ack, latched request, sticky flags
   int own = -1, t = 0, last = 1, pend = -1, mbeats = 0, w;
   bit zero = 0, fin = 0, ea, rx, idle;
   logic [25:0] ma = 0;
   logic [7:0] ml = 0;
   bit e_len = 0, e_cnt = 0, e_to = 0;
   // observations used by the literal checks
   int cyc = 0, n_trig, n_de0, n_de1, n_done0, n_done1, trig_cyc, ack_cyc, done_cyc, to_cyc;
   logic [25:0] trig_addr;
   logic [7:0] trig_len;
   logic [3:0] ack_hist;
   bit prev_to = 0;

   axi_rd_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ack(req0_ack),
      .req0_done(req0_done), .req0_data(req0_data), .req0_data_en(req0_data_en),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ack(req1_ack),
      .req1_done(req1_done), .req1_data(req1_data), .req1_data_en(req1_data_en),
      .m_rd_trig(m_rd_trig), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len), .m_rd_ready(m_rd_ready),
      .m_rd_done(m_rd_done), .m_rd_data(m_rd_data), .m_rd_data_en(m_rd_data_en),
      .busy(busy), .len_err(len_err), .cnt_err(cnt_err), .timeout(timeout));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) if (en) begin
      cyc++;
      idle = own < 0;
      w = (req0_valid && req1_valid) ? 1 - last : (req1_valid ? 1 : 0);
      ea = idle && m_rd_ready && (req0_valid || req1_valid);
      rx = !idle && t >= (zero ? 1 : 2);
      chk("ack0", req0_ack, ea && w == 0);
      chk("ack1", req1_ack, ea && w == 1);
      chk("trig", m_rd_trig, !idle && !zero && t == 1);
      chk("busy", busy, !idle);
      chk("done0", req0_done, pend == 0);
      chk("done1", req1_done, pend == 1);
      chk("m_addr", m_rd_addr, ma);
      chk("m_len", m_rd_len, ml);
      chk("data_en0", req0_data_en, m_rd_data_en && rx && own == 0);
      chk("data_en1", req1_data_en, m_rd_data_en && rx && own == 1);
      chk("data0", req0_data, m_rd_data);
      chk("data1", req1_data, m_rd_data);
      chk("len_err", len_err, e_len);
      chk("cnt_err", cnt_err, e_cnt);
      chk("timeout", timeout, e_to);
      if (m_rd_trig) begin n_trig++; trig_cyc = cyc; trig_addr = m_rd_addr; trig_len = m_rd_len; end
      if (req0_ack || req1_ack) begin ack_cyc = cyc; ack_hist = {ack_hist[2:0], req1_ack}; end
      if (req0_done || req1_done) done_cyc = cyc;
      n_de0 += int'(req0_data_en); n_de1 += int'(req1_data_en);
      n_done0 += int'(req0_done); n_done1 += int'(req1_done);
      if (timeout && !prev_to) to_cyc = cyc;
      prev_to = timeout;
      if (rst) begin
         own = -1; last = 1; pend = -1; ma = 0; ml = 0; zero = 0; fin = 0;
         e_len = 0; e_cnt = 0; e_to = 0;
      end else if (idle) begin
         pend = -1;
         if (ea) begin
            own = w; t = 1; fin = 0;
            ma = w ? req1_addr : req0_addr;
            ml = w ? req1_len : req0_len;
            zero = ml == 0;
            if (zero) e_len = 1;
         end
      end else if (fin || zero) begin
         pend = own; last = own; own = -1;
      end else if (t == 1) begin
         mbeats = 0; t = 2;
      end else begin
         mbeats += int'(m_rd_data_en);
         if (m_rd_done) begin
            if (mbeats != int'(ml)) e_cnt = 1;
            fin = 1;
         end else if (t - 2 == TO - 1) begin
            e_to = 1; fin = 1;
         end
         t++;
      end
   end

   // read-master responder: beats start the cycle after the trigger
   initial begin
      m_rd_ready = 1; m_rd_data_en = 0; m_rd_done = 0; m_rd_data = 0;
      forever begin
         @(posedge clk); #1;
         m_rd_data_en = 0; m_rd_done = 0;
         if (m_rd_trig && !rst) begin
            m_rd_ready = 0;
            for (int i = 0; i < bfm_beats; i++) begin
               @(posedge clk); #1;
               m_rd_data_en = 1; m_rd_data = $urandom;
               m_rd_done = bfm_done && bfm_same && i == bfm_beats - 1;
            end
            @(posedge clk); #1;
            m_rd_data_en = 0; m_rd_done = 0;
            if (!bfm_done) begin repeat (20) @(posedge clk); #1; end
            else if (!(bfm_same && bfm_beats > 0)) m_rd_done = 1;
            m_rd_ready = 1;
         end
      end
   end

   task automatic clr();
      n_trig = 0; n_de0 = 0; n_de1 = 0; n_done0 = 0; n_done1 = 0; ack_hist = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      clr();
   endtask

   task automatic request(input bit n, input logic [25:0] a, input logic [7:0] l);
      bit got = 0;
      @(posedge clk); #1;
      if (n) begin req1_valid = 1; req1_addr = a; req1_len = l; end
      else begin req0_valid = 1; req0_addr = a; req0_len = l; end
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = n ? req1_ack : req0_ack;
      end
      chk("ack_seen", got, 1);
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
   endtask

   task automatic wait_done(input string name);
      bit got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = req0_done || req1_done;
      end
      chk(name, got, 1);
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      bit got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = m_rd_ready;
      end
      chk("ready_seen", got, 1);
   endtask

   initial begin
      int na, nb;
      bit got;
      repeat (2) @(posedge clk); #1 rst = 0; en = 1;
      clr();
      // single request
      bfm_beats = 8; bfm_done = 1; bfm_same = 0;
      request(0, 26'h100, 8);
      wait_done("s1_done");
      chk("s1_trig_cnt", n_trig, 1);
      chk("s1_trig_lat", trig_cyc - ack_cyc, 1);
      chk("s1_trig_addr", trig_addr, 26'h100);
      chk("s1_trig_len", trig_len, 8);
      chk("s1_de0", n_de0, 8);
      chk("s1_de1", n_de1, 0);
      chk("s1_done0", n_done0, 1);
      chk("s1_errs", {len_err, cnt_err, timeout}, 0);
      // contention, done arriving with the last beat
      do_reset();
      bfm_beats = 4; bfm_same = 1;
      @(posedge clk); #1;
      req0_valid = 1; req0_addr = 26'h200; req0_len = 4;
      req1_valid = 1; req1_addr = 26'h300; req1_len = 4;
      na = 0;
      for (int i = 0; i < 400 && na < 4; i++) begin
         @(negedge clk);
         if (req0_ack || req1_ack) na++;
      end
      chk("s2_acks", na, 4);
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); got = n_done0 + n_done1 == 4; end
      chk("s2_all_done", got, 1);
      repeat (2) @(posedge clk); #1;
      chk("s2_order", ack_hist, 4'b0101);
      chk("s2_de0", n_de0, 8);
      chk("s2_de1", n_de1, 8);
      chk("s2_cnt_err", cnt_err, 0);
      // zero length
      do_reset();
      request(1, 26'h40, 0);
      wait_done("s3_done");
      chk("s3_done_lat", done_cyc - ack_cyc, 2);
      chk("s3_trig_cnt", n_trig, 0);
      chk("s3_len_err", len_err, 1);
      chk("s3_done1", n_done1, 1);
      // short return
      do_reset();
      bfm_beats = 7; bfm_same = 0;
      request(0, 26'h500, 8);
      wait_done("s4_done");
      chk("s4_cnt_err", cnt_err, 1);
      chk("s4_done0", n_done0, 1);
      chk("s4_de0", n_de0, 7);
      chk("s4_busy", busy, 0);
      // watchdog
      do_reset();
      bfm_beats = 0; bfm_done = 0;
      request(0, 26'h600, 5);
      wait_done("s5_done");
      chk("s5_to_lat", to_cyc - trig_cyc, 17);
      chk("s5_timeout", timeout, 1);
      chk("s5_done0", n_done0, 1);
      wait_ready();
      bfm_beats = 2; bfm_done = 1;
      request(1, 26'h700, 2);
      wait_done("s5_next_done");
      chk("s5_de1", n_de1, 2);
      chk("s5_done1", n_done1, 1);
      chk("s5_cnt_err", cnt_err, 0);
      // reset in the middle of WAIT
      do_reset();
      bfm_beats = 8;
      request(0, 26'h800, 8);
      nb = 0;
      for (int i = 0; i < 200 && nb < 3; i++) begin
         @(negedge clk);
         if (req0_data_en) nb++;
      end
      chk("s6_beats", nb, 3);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("s6_busy", busy, 0);
      chk("s6_trig", m_rd_trig, 0);
      chk("s6_addr", m_rd_addr, 0);
      chk("s6_len", m_rd_len, 0);
      chk("s6_de0", req0_data_en, 0);
      chk("s6_done0", req0_done, 0);
      clr();
      wait_ready();
      bfm_beats = 3;
      request(1, 26'h900, 3);
      wait_done("s6_next_done");
      chk("s6_no_done0", n_done0, 0);
      chk("s6_done1", n_done1, 1);
      chk("s6_de1", n_de1, 3);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
